approx_shift_add_multiplier_ctrl: RTL and testbench



---
 rtl/approx_shift_add_multiplier_ctrl_if.sv | 29 ++
 rtl/approx_shift_add_multiplier_ctrl.sv | 94 +++++++++
 tb/tb_approx_shift_add_multiplier_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/approx_shift_add_multiplier_ctrl_if.sv
// Handshake and adder-facing bus of the shift-and-add multiplier controller.
// slave = controller side, master = requester/consumer/adder side.
interface approx_shift_add_multiplier_ctrl_if #(
  parameter int OP_WIDTH   = 8,
  parameter int MASK_WIDTH = 3
);
  logic                    in_valid;
  logic                    in_ready;
  logic [OP_WIDTH-1:0]     a;
  logic [OP_WIDTH-1:0]     b;
  logic [MASK_WIDTH-1:0]   mask_in;
  logic [2*OP_WIDTH-1:0]   adder_in1;
  logic [2*OP_WIDTH-1:0]   adder_in2;
  logic [MASK_WIDTH-1:0]   adder_mask;
  logic [2*OP_WIDTH-1:0]   adder_out;
  logic                    out_valid;
  logic                    out_ready;
  logic [2*OP_WIDTH-1:0]   product;

  modport slave (
    input  in_valid, a, b, mask_in, adder_out, out_ready,
    output in_ready, adder_in1, adder_in2, adder_mask, out_valid, product
  );

  modport master (
    output in_valid, a, b, mask_in, adder_out, out_ready,
    input  in_ready, adder_in1, adder_in2, adder_mask, out_valid, product
  );
endinterface

// File: rtl/approx_shift_add_multiplier_ctrl.sv
// Sequential shift-and-add multiplier driving an external approximate adder, one step per clock.
// Optional early termination on exhausted multiplier bits: define ZERO_SKIP_EN.
module approx_shift_add_multiplier_ctrl #(
  parameter int OP_WIDTH   = 8,
  parameter int MASK_WIDTH = 3
) (
  input logic clk,
  input logic rst_n,
  approx_shift_add_multiplier_ctrl_if.slave bus
);
  localparam int PW = 2 * OP_WIDTH;
  localparam int CW = (OP_WIDTH > 1) ? $clog2(OP_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(OP_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t                state, state_next;
  logic [PW-1:0]         acc;
  logic [PW-1:0]         mcand;
  logic [OP_WIDTH-1:0]   mplier;
  logic [CW-1:0]         count;
  logic [MASK_WIDTH-1:0] mask_r;
  logic                  accept;
  logic                  last_step;

  assign accept = bus.in_valid && (state == IDLE);

`ifdef ZERO_SKIP_EN
  // Once the remaining multiplier bits are all zero, later steps would only add 0.
  assign last_step = (count == LAST) || ((mplier >> 1) == '0);
`else
  assign last_step = (count == LAST);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next     = state;
    bus.in_ready   = 1'b0;
    bus.out_valid  = 1'b0;
    bus.adder_in1  = '0;
    bus.adder_in2  = '0;
    bus.adder_mask = mask_r;
    bus.product    = '0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
`ifdef ZERO_SKIP_EN
          state_next = (bus.b == '0) ? DONE : ACC;
`else
          state_next = ACC;
`endif
        end
      end
      ACC: begin
        bus.adder_in1 = acc;
        bus.adder_in2 = mplier[0] ? mcand : '0;
        if (last_step) state_next = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        bus.product   = acc;
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
      mask_r <= '0;
    end else if (accept) begin
      acc    <= '0;
      mcand  <= PW'(bus.a);
      mplier <= bus.b;
      count  <= '0;
      mask_r <= bus.mask_in;
    end else if (state == ACC) begin
      // Adder result is taken at full product width; no carry-out exists.
      acc    <= bus.adder_out;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + 1'b1;
    end
  end
endmodule

// File: tb/tb_approx_shift_add_multiplier_ctrl.sv
// Directed bench: drives the adder port with an exact or approximate stub and scoreboards products/latency.
module tb_approx_shift_add_multiplier_ctrl;
  localparam int OPW = 8;
  localparam int MW  = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic approx_en = 1'b0;
  always #5 clk = ~clk;

  approx_shift_add_multiplier_ctrl_if #(.OP_WIDTH(OPW), .MASK_WIDTH(MW)) bus ();

  approx_shift_add_multiplier_ctrl #(.OP_WIDTH(OPW), .MASK_WIDTH(MW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Stand-in approximate adder: low 'mask' bits are OR-ed, upper bits added without carry-in.
  function automatic logic [15:0] approx_add(input logic [15:0] x, input logic [15:0] y,
                                             input logic [2:0] m);
    logic [15:0] lm;
    lm = (16'h0001 << m) - 16'h0001;
    return ((x & ~lm) + (y & ~lm)) | ((x | y) & lm);
  endfunction

  always_comb begin
    if (approx_en) bus.adder_out = approx_add(bus.adder_in1, bus.adder_in2, bus.adder_mask);
    else           bus.adder_out = bus.adder_in1 + bus.adder_in2;
  end

  typedef struct {
    logic [15:0] prod;
    int          lat;
  } exp_t;
  exp_t sb[$];

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] m, input logic apx);
    logic [15:0] acc, addend;
    acc = 16'h0;
    for (int i = 0; i < OPW; i++) begin
      addend = b[i] ? (16'(a) << i) : 16'h0;
      acc = apx ? approx_add(acc, addend, m) : acc + addend;
    end
    return acc;
  endfunction

  // Edges counted after the accept edge until out_valid is seen.
  function automatic int exp_lat(input logic [7:0] b);
`ifdef ZERO_SKIP_EN
    int hb;
    if (b == 8'h00) return 0;  // DONE is entered on the accept edge itself
    hb = 0;
    for (int i = 0; i < OPW; i++) if (b[i]) hb = i;
    return hb + 1;
`else
    return OPW;
`endif
  endfunction

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] m);
    exp_t e;
    int   edges;
    sb.push_back('{model(a, b, m, approx_en), exp_lat(b)});
    @(negedge clk);
    bus.a = a; bus.b = b; bus.mask_in = m; bus.in_valid = 1'b1;
    check("in_ready_idle", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.mask_in  = ~m;
    check("adder_mask", 32'(bus.adder_mask), 32'(m));
    if (!bus.out_valid) begin
      check("adder_in1_step0", 32'(bus.adder_in1), 32'd0);
      check("adder_in2_step0", 32'(bus.adder_in2), b[0] ? 32'(a) : 32'd0);
    end
    edges = 0;
    while (!bus.out_valid && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    e = sb.pop_front();
    check("latency", 32'(edges), 32'(e.lat));
    check("product", 32'(bus.product), 32'(e.prod));
    $display("[TB] a=%02h b=%02h mask=%0d product=%04h latency=%0d", a, b, m, bus.product, edges);
    if (bus.out_ready) begin
      @(posedge clk); #1;
      check("idle_after_done", {bus.in_ready, bus.out_valid}, 32'b10);
    end
  endtask

  logic [15:0] held;

  initial begin
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.mask_in = '0; bus.out_ready = 1'b1;
    #12;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_outputs", {bus.product, bus.adder_in1}, 32'd0);
    check("rst_in2_mask", {bus.adder_in2, 13'd0, bus.adder_mask}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Exact multiplication, back-to-back, zero/one/top-bit multipliers
    run_op(8'hAA, 8'hCC, 3'b011);
    run_op(8'hFF, 8'hFF, 3'b000);
    run_op(8'h01, 8'h01, 3'b000);
    run_op(8'h5A, 8'h00, 3'b000);
    run_op(8'h37, 8'h01, 3'b101);
    run_op(8'h37, 8'h80, 3'b010);

    // Back-pressure: DONE holds, new requests are ignored
    bus.out_ready = 1'b0;
    run_op(8'h12, 8'h34, 3'b001);
    held = bus.product;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1; bus.a = 8'($urandom); bus.b = 8'($urandom);
      @(posedge clk); #1;
      check("hold_product", 32'(bus.product), 32'(held));
      check("hold_handshake", {bus.in_ready, bus.out_valid}, 32'b01);
    end
    @(negedge clk); bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("release_idle", {bus.in_ready, bus.out_valid}, 32'b10);
    run_op(8'h03, 8'h07, 3'b000);

    // Asynchronous reset in the middle of accumulation
    @(negedge clk);
    bus.a = 8'hAA; bus.b = 8'hCC; bus.mask_in = 3'b011; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_handshake", {bus.in_ready, bus.out_valid}, 32'b10);
    check("abort_adder_in", {bus.adder_in1, bus.adder_in2}, 32'd0);
    check("abort_mask_prod", {13'd0, bus.adder_mask, bus.product}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    #1 check("post_reset_ready", 32'(bus.in_ready), 32'd1);
    run_op(8'h03, 8'h05, 3'b000);

    // Approximate adder in the loop
    approx_en = 1'b1;
    run_op(8'hAA, 8'hCC, 3'b011);
    run_op(8'hF3, 8'h5D, 3'b111);
    approx_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
